demux_4bit_reg: RTL and testbench
=================================

// Module: demux_4bit_reg
//
// PURPOSE
//   Registered 1-to-2 demultiplexer: the inverse of the 2:1 operand mux.
//   Routes a stream of WIDTH-bit operands from one producer to one of two consumers.
//   SelectorInput chooses the consumer; 0 selects Out1 and 1 selects Out2, matching the mux convention.
//   Each output has its own DEPTH-entry FIFO, so one stalled consumer never blocks the other.
//   The block sits between the operand fetch path and the two datapath consumers of the 16-bit ISA core.
//
// PARAMETERS
//   WIDTH  4  data width of each operand
//   DEPTH  2  entries per output FIFO; must be a power of two and >= 2
//   CW     $clog2(DEPTH)+1  width of the occupancy count (derived, do not override)
//
// PORTS
//   Clock          in   1      single clock; all state updates on the rising edge
//   Reset          in   1      asynchronous, active-high reset
//   InValid        in   1      producer presents an operand
//   InReady        out  1      the selected channel can accept an operand
//   SelectorInput  in   1      destination: 0 -> Out1, 1 -> Out2; sampled with InValid
//   InData         in   WIDTH  operand to route
//   Out1Valid      out  1      channel 1 FIFO is non-empty
//   Out1Ready      in   1      consumer 1 accepts the head entry
//   Out1Data       out  WIDTH  channel 1 head entry
//   Out1Count      out  CW     channel 1 occupancy, 0..DEPTH
//   Out2Valid      out  1      channel 2 FIFO is non-empty
//   Out2Ready      in   1      consumer 2 accepts the head entry
//   Out2Data       out  WIDTH  channel 2 head entry
//   Out2Count      out  CW     channel 2 occupancy, 0..DEPTH
//
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - all pointers and counts go to 0; storage is cleared to 0.
//     - OutNValid=0, OutNData=0, OutNCount=0.
//     - InReady = !full of the selected channel, so it reads 1 after reset.
//   - Reset mid-operation discards all queued operands; no partial state survives.
//   - Push: InValid && InReady at an edge writes InData into the channel given by SelectorInput.
//     - The other channel is untouched.
//   - InReady = !full[SelectorInput]. It is combinational from SelectorInput and registered counts only.
//     - There is no path from OutNReady to InReady.
//     - A push into a full channel is never accepted, even if that channel pops in the same cycle.
//   - Pop: OutNValid && OutNReady at an edge advances read pointer N.
//     - OutNData shows the head entry from the register array via the read pointer.
//     - OutNData is stable while OutNValid=1 and OutNReady=0.
//   - Latency: an operand pushed at edge k is visible on OutNValid/OutNData after edge k.
//     - That gives 1 cycle through an empty FIFO; there is no same-cycle bypass.
//   - Simultaneous push and pop on the same non-full channel: count is unchanged and both pointers advance.
//   - Push and pop on different channels in the same cycle are fully independent.
//   - Pointers wrap modulo DEPTH. Count saturates by construction (pushes are blocked at DEPTH).
//     - An empty channel never pops because Valid=0.
//   - Ordering: FIFO order is preserved per channel. There is no ordering relation across channels.
//   - InValid=0 means no push, regardless of SelectorInput.
//     - SelectorInput may change freely while InValid=0.
//   - Width rule: data passes through bit-exact with no extension or truncation. Count arithmetic is CW bits.
//
// STRUCTURE
//   - Shared definitions (demux_defs.vh): SEL_OUT1=1'b0, SEL_OUT2=1'b1, default WIDTH and DEPTH.
//     - The Mux_4bit select convention references the same constants.
//   - One sub-module, demux_fifo_chan: one DEPTH x WIDTH FIFO with push/pop, valid, full and count.
//     - It is instantiated twice.
//     - The top level holds only select decode, push steering and InReady.
//
// TESTING
//   1. Reset:
//      - Stimulus: assert Reset with InValid=1.
//      - Required: all OutNValid=0, counts=0, InReady=1. Deasserting Reset gives no spurious push.
//   2. Routing:
//      - Stimulus: push 4'hA with Sel=0, then 4'h5 with Sel=1, both outputs Ready=1.
//      - Required: Out1Data=A one cycle after its push, Out2Data=5 one cycle after its push, each valid for exactly one cycle.
//   3. Fill and stall:
//      - Stimulus: Out1Ready=0; push 1,2,3 with Sel=0.
//      - Required: 1 and 2 are accepted, Out1Count=2, InReady=0 while Sel=0.
//      - Required: with Sel=1, InReady=1 and pushing 7 reaches Out2.
//   4. Drain and wrap:
//      - Stimulus: keep channel 1 full, raise Out1Ready, push 3,4,5 back-to-back with Sel=0.
//      - Required: Out1 emits 1,2,3,4,5 in order; pointers wrap; count never exceeds 2.
//   5. Concurrent push and pop:
//      - Stimulus: channel 2 at count 1 (9); push B with Sel=1 while Out2Ready=1.
//      - Required: 9 pops, Out2Count stays 1, Out2Data=B next cycle.
//   6. Reset mid-stream:
//      - Stimulus: both channels at count 2; assert Reset asynchronously mid-cycle.
//      - Required: Valid and Count drop to 0 immediately; after release, the next push of 4'hF appears alone.

Source files
------------

// File: rtl/demux_4bit_reg_pkg.sv
// Shared definitions for the registered 1-to-2 operand demultiplexer.
// The select encoding matches the 2:1 operand mux: 0 -> Out1, 1 -> Out2.
package demux_4bit_reg_pkg;

  typedef enum logic {
    SEL_OUT1 = 1'b0,
    SEL_OUT2 = 1'b1
  } sel_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/demux_fifo_chan.sv
// One output channel: a DEPTH x WIDTH register FIFO with valid, full and occupancy count.
// The head entry is read straight from the register array, so there is no bypass path.
module demux_fifo_chan
  import demux_4bit_reg_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/demux_4bit_reg.sv
// Registered 1-to-2 demultiplexer: steers producer operands into one of two
// independent FIFOs so a stalled consumer never blocks the other one.
module demux_4bit_reg
  import demux_4bit_reg_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic             SelectorInput,
  input  logic [WIDTH-1:0] InData,
  output logic             Out1Valid,
  input  logic             Out1Ready,
  output logic [WIDTH-1:0] Out1Data,
  output logic [CW-1:0]    Out1Count,
  output logic             Out2Valid,
  input  logic             Out2Ready,
  output logic [WIDTH-1:0] Out2Data,
  output logic [CW-1:0]    Out2Count
);

  logic sel_out2;
  logic full1, full2;
  logic push1, push2;

  // InReady depends only on the select and registered fullness, never on consumer ready.
  assign sel_out2 = (SelectorInput == SEL_OUT2);
  assign InReady  = sel_out2 ? !full2 : !full1;
  assign push1    = InValid && InReady && !sel_out2;
  assign push2    = InValid && InReady && sel_out2;

  demux_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan1 (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (push1),
    .data_i  (InData),
    .pop_i   (Out1Ready),
    .valid_o (Out1Valid),
    .full_o  (full1),
    .data_o  (Out1Data),
    .count_o (Out1Count)
  );

  demux_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan2 (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (push2),
    .data_i  (InData),
    .pop_i   (Out2Ready),
    .valid_o (Out2Valid),
    .full_o  (full2),
    .data_o  (Out2Data),
    .count_o (Out2Count)
  );

endmodule

// File: tb/tb_demux_4bit_reg.sv
// Self-checking bench for demux_4bit_reg: directed pushes feed per-channel
// expectation queues, a negedge monitor checks every completed pop.
module tb_demux_4bit_reg;

  localparam int WIDTH = 4;
  localparam int CW    = 2;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic             SelectorInput;
  logic [WIDTH-1:0] InData;
  logic             Out1Valid, Out1Ready;
  logic [WIDTH-1:0] Out1Data;
  logic [CW-1:0]    Out1Count;
  logic             Out2Valid, Out2Ready;
  logic [WIDTH-1:0] Out2Data;
  logic [CW-1:0]    Out2Count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp1_q [$];
  logic [WIDTH-1:0] exp2_q [$];
  bit mon_en = 1'b0;

  demux_4bit_reg dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .InValid       (InValid),
    .InReady       (InReady),
    .SelectorInput (SelectorInput),
    .InData        (InData),
    .Out1Valid     (Out1Valid),
    .Out1Ready     (Out1Ready),
    .Out1Data      (Out1Data),
    .Out1Count     (Out1Count),
    .Out2Valid     (Out2Valid),
    .Out2Ready     (Out2Ready),
    .Out2Data      (Out2Data),
    .Out2Count     (Out2Count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives one operand for one edge; exp_acc is the hand-computed acceptance.
  task automatic push(input logic sel, input logic [WIDTH-1:0] d, input logic exp_acc);
    InValid       = 1'b1;
    SelectorInput = sel;
    InData        = d;
    #1;
    check("in_ready", 32'(InReady), 32'(exp_acc));
    if (exp_acc) begin
      if (sel) exp2_q.push_back(d);
      else     exp1_q.push_back(d);
    end
    tick();
    InValid = 1'b0;
  endtask

  // A handshake seen at the negedge completes at the following posedge.
  always @(negedge Clock) begin
    if (mon_en && !Reset) begin
      if (Out1Valid && Out1Ready) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out1_unexpected: got %0h required no output", Out1Data);
        end else begin
          check("out1_data", 32'(Out1Data), 32'(exp1_q.pop_front()));
        end
      end
      if (Out2Valid && Out2Ready) begin
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out2_unexpected: got %0h required no output", Out2Data);
        end else begin
          check("out2_data", 32'(Out2Data), 32'(exp2_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: got no end of run required finish before 20000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    Reset         = 1'b1;
    InValid       = 1'b1;
    SelectorInput = 1'b0;
    InData        = 4'hF;
    Out1Ready     = 1'b0;
    Out2Ready     = 1'b0;
    tick();
    tick();

    // 1. Reset with InValid held high
    check("rst_out1_valid", 32'(Out1Valid), 32'd0);
    check("rst_out2_valid", 32'(Out2Valid), 32'd0);
    check("rst_out1_count", 32'(Out1Count), 32'd0);
    check("rst_out2_count", 32'(Out2Count), 32'd0);
    check("rst_out1_data", 32'(Out1Data), 32'd0);
    check("rst_in_ready", 32'(InReady), 32'd1);
    InValid = 1'b0;
    Reset   = 1'b0;
    tick();
    check("post_rst_count1", 32'(Out1Count), 32'd0);
    check("post_rst_valid1", 32'(Out1Valid), 32'd0);
    mon_en = 1'b1;

    // 2. Routing, both consumers ready
    Out1Ready = 1'b1;
    Out2Ready = 1'b1;
    push(1'b0, 4'hA, 1'b1);
    check("route_out1_valid", 32'(Out1Valid), 32'd1);
    check("route_out1_data", 32'(Out1Data), 32'hA);
    check("route_out2_idle", 32'(Out2Valid), 32'd0);
    push(1'b1, 4'h5, 1'b1);
    check("route_out1_one_cycle", 32'(Out1Valid), 32'd0);
    check("route_out2_valid", 32'(Out2Valid), 32'd1);
    check("route_out2_data", 32'(Out2Data), 32'h5);
    tick();
    check("route_out2_one_cycle", 32'(Out2Valid), 32'd0);

    // 3. Fill channel 1 and stall it; channel 2 stays open
    Out1Ready = 1'b0;
    push(1'b0, 4'h1, 1'b1);
    push(1'b0, 4'h2, 1'b1);
    check("fill_count1", 32'(Out1Count), 32'd2);
    push(1'b0, 4'h3, 1'b0);
    check("stall_count1", 32'(Out1Count), 32'd2);
    check("stall_head1", 32'(Out1Data), 32'h1);
    push(1'b1, 4'h7, 1'b1);
    check("other_chan_valid", 32'(Out2Valid), 32'd1);
    check("other_chan_data", 32'(Out2Data), 32'h7);
    check("other_chan_count1", 32'(Out1Count), 32'd2);
    tick();

    // 4. Drain and wrap: full blocks the first attempt even while popping
    Out1Ready = 1'b1;
    push(1'b0, 4'h3, 1'b0);
    check("drain_count_a", 32'(Out1Count), 32'd1);
    push(1'b0, 4'h3, 1'b1);
    check("drain_count_b", 32'(Out1Count), 32'd1);
    push(1'b0, 4'h4, 1'b1);
    check("drain_count_c", 32'(Out1Count), 32'd1);
    push(1'b0, 4'h5, 1'b1);
    check("drain_count_d", 32'(Out1Count), 32'd1);
    check("drain_head", 32'(Out1Data), 32'h5);
    tick();
    check("drain_empty", 32'(Out1Count), 32'd0);

    // 5. Concurrent push and pop on channel 2
    Out2Ready = 1'b0;
    push(1'b1, 4'h9, 1'b1);
    check("conc_count_pre", 32'(Out2Count), 32'd1);
    Out2Ready = 1'b1;
    push(1'b1, 4'hB, 1'b1);
    check("conc_count", 32'(Out2Count), 32'd1);
    check("conc_data", 32'(Out2Data), 32'hB);
    tick();
    check("conc_empty", 32'(Out2Count), 32'd0);

    // 6. Reset mid-stream with both channels full
    Out1Ready = 1'b0;
    Out2Ready = 1'b0;
    push(1'b0, 4'h1, 1'b1);
    push(1'b0, 4'h2, 1'b1);
    push(1'b1, 4'h3, 1'b1);
    push(1'b1, 4'h4, 1'b1);
    check("pre_rst_count1", 32'(Out1Count), 32'd2);
    check("pre_rst_count2", 32'(Out2Count), 32'd2);
    #2;
    Reset = 1'b1;
    exp1_q.delete();
    exp2_q.delete();
    #1;
    check("mid_rst_valid1", 32'(Out1Valid), 32'd0);
    check("mid_rst_valid2", 32'(Out2Valid), 32'd0);
    check("mid_rst_count1", 32'(Out1Count), 32'd0);
    check("mid_rst_count2", 32'(Out2Count), 32'd0);
    tick();
    Reset     = 1'b0;
    Out1Ready = 1'b1;
    Out2Ready = 1'b1;
    push(1'b0, 4'hF, 1'b1);
    check("after_rst_valid1", 32'(Out1Valid), 32'd1);
    check("after_rst_data1", 32'(Out1Data), 32'hF);
    check("after_rst_count1", 32'(Out1Count), 32'd1);
    check("after_rst_valid2", 32'(Out2Valid), 32'd0);
    tick();
    check("after_rst_alone", 32'(Out1Valid), 32'd0);
    tick();

    check("sb_empty1", 32'(exp1_q.size()), 32'd0);
    check("sb_empty2", 32'(exp2_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
